// File: rtl/gyro_sample_fetch.sv
// gyro_sample_fetch
// -----------------
// Pairs the MPU6050 gyro high/low register bytes coming from the I2C reader
// into a signed 16-bit sample. After reset or a recal request, the block averages
// 2^CAL_SHIFT samples to find the zero-rate offset. It then outputs each later
// sample minus that offset. The subtraction saturates to the 16-bit signed range.
//
// Optional feature macro: GYRO_DEADBAND_EN
//   When it is defined, corrected results with |result| <= DEADBAND are output
//   as zero. The is_read strobe is still issued for those results.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-high
//   byte_in     data byte from the I2C reader
//   byte_valid  byte_in is valid this cycle
//   byte_sof    with byte_valid: byte_in is the high byte (GYRO_xOUT_H)
//   recal       single-cycle request to restart offset calibration
//   G           offset-corrected signed gyro sample (held between strobes)
//   is_read     one-cycle strobe, G valid while high
//   calib_done  high once a valid offset is in use
//   gy_offset   current signed offset (debug)

module gyro_sample_fetch #(
    parameter int CAL_SHIFT = 8,
    parameter int DEADBAND  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_sof,
    input  logic        recal,
    output logic [15:0] G,
    output logic        is_read,
    output logic        calib_done,
    output logic [15:0] gy_offset
);

    localparam int ACC_W = 16 + CAL_SHIFT;

    localparam logic [0:0] ST_CALIB = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

`ifdef GYRO_DEADBAND_EN
    localparam logic DB_EN = 1'b1;
`else
    localparam logic DB_EN = 1'b0;
`endif
    localparam logic signed [16:0] DB_LIM = 17'(DEADBAND);

    localparam logic [CAL_SHIFT-1:0] CNT_ONE = CAL_SHIFT'(1'b1);

    // Compute a - b in 17 bits and clamp the result to [-32768, 32767].
    function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] d;
        logic [15:0] res;
        d = {a[15], a} - {b[15], b};
        if (d[16] != d[15]) begin
            res = d[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            res = d[15:0];
        end
        return res;
    endfunction

    // Replace small magnitudes with zero when the deadband option is built in.
    function automatic logic [15:0] apply_deadband(input logic [15:0] v);
        logic signed [16:0] sv;
        logic [15:0]        res;
        sv = $signed({v[15], v});
        if (DB_EN && (sv <= DB_LIM) && (sv >= -DB_LIM)) begin
            res = 16'h0000;
        end else begin
            res = v;
        end
        return res;
    endfunction

    logic [7:0]             hi_r;
    logic                   have_hi_r;
    logic [0:0]             state_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [CAL_SHIFT-1:0]   cnt_r;
    logic [15:0]            g_r;
    logic                   is_read_r;
    logic                   calib_done_r;
    logic [15:0]            offset_r;

    logic                   pair_done_s;
    logic [15:0]            raw_s;
    logic signed [ACC_W-1:0] acc_sum_s;
    logic                   last_sample_s;
    logic [15:0]            corr_s;

    assign pair_done_s   = byte_valid & ~byte_sof & have_hi_r;
    assign raw_s         = {hi_r, byte_in};
    assign acc_sum_s     = acc_r + $signed({{CAL_SHIFT{raw_s[15]}}, raw_s});
    // The counter only has to reach 2^CAL_SHIFT-1, so all-ones marks the final sample.
    assign last_sample_s = &cnt_r;
    assign corr_s        = apply_deadband(sat_sub(raw_s, offset_r));

    // Byte pairing: remember the most recent high byte until a low byte closes the pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r      <= 8'h00;
            have_hi_r <= 1'b0;
        end else if (byte_valid && byte_sof) begin
            hi_r      <= byte_in;
            have_hi_r <= 1'b1;
        end else if (pair_done_s) begin
            have_hi_r <= 1'b0;
        end else begin
            have_hi_r <= have_hi_r;
        end
    end

    // Calibration/run control. A recal request overrides any pair that arrives in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_CALIB;
            acc_r        <= '0;
            cnt_r        <= '0;
            g_r          <= 16'h0000;
            is_read_r    <= 1'b0;
            calib_done_r <= 1'b0;
            offset_r     <= 16'h0000;
        end else begin
            is_read_r <= 1'b0;
            if (recal) begin
                state_r      <= ST_CALIB;
                calib_done_r <= 1'b0;
                acc_r        <= '0;
                cnt_r        <= '0;
            end else begin
                case (state_r)
                    ST_CALIB: begin
                        if (pair_done_s) begin
                            if (last_sample_s) begin
                                // Upper 16 bits of the sum: arithmetic shift, rounds toward -inf.
                                offset_r     <= acc_sum_s[ACC_W-1:CAL_SHIFT];
                                acc_r        <= '0;
                                cnt_r        <= '0;
                                calib_done_r <= 1'b1;
                                state_r      <= ST_RUN;
                            end else begin
                                acc_r <= acc_sum_s;
                                cnt_r <= cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (pair_done_s) begin
                            g_r       <= corr_s;
                            is_read_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= ST_CALIB;
                    end
                endcase
            end
        end
    end

    assign G          = g_r;
    assign is_read    = is_read_r;
    assign calib_done = calib_done_r;
    assign gy_offset  = offset_r;

endmodule

// File: tb/tb_gyro_sample_fetch.sv
// Directed testbench for gyro_sample_fetch, built with CAL_SHIFT=2 (4-sample calibration).
// Inputs change on the falling edge. Outputs are sampled 1 time unit after the rising edge.
module tb_gyro_sample_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_sof;
    logic        recal;
    logic [15:0] G;
    logic        is_read;
    logic        calib_done;
    logic [15:0] gy_offset;

    int n_vec  = 0;
    int n_fail = 0;
    int strobe_cnt  = 0;
    int exp_strobes = 0;

`ifdef GYRO_DEADBAND_EN
    localparam logic [15:0] EXP_G_SMALL3 = 16'h0000;
    localparam logic [15:0] EXP_G_SMALL4 = 16'h0000;
`else
    localparam logic [15:0] EXP_G_SMALL3 = 16'h0003;
    localparam logic [15:0] EXP_G_SMALL4 = 16'h0004;
`endif

    gyro_sample_fetch #(.CAL_SHIFT(2), .DEADBAND(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_sof   (byte_sof),
        .recal      (recal),
        .G          (G),
        .is_read    (is_read),
        .calib_done (calib_done),
        .gy_offset  (gy_offset)
    );

    always #5 clk = ~clk;

    // Count every strobe cycle so that unexpected strobes are caught globally.
    always @(negedge clk) begin
        if (is_read === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sof, input logic rc);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        byte_sof   = sof;
        recal      = rc;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_sof   = 1'b0;
        recal      = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] raw, input logic rc);
        send_byte(raw[15:8], 1'b1, 1'b0);
        send_byte(raw[7:0], 1'b0, rc);
    endtask

    task automatic pulse_recal();
        @(negedge clk);
        recal = 1'b1;
        @(posedge clk);
        #1;
        recal = 1'b0;
        check_vec("recal_calib_done_low", {31'd0, calib_done}, 32'd0);
    endtask

    // Four calibration samples; the offset must be in use right after the 4th low byte.
    task automatic cal4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] d, input logic [15:0] exp_off);
        send_pair(a, 1'b0);
        send_pair(b, 1'b0);
        send_pair(c, 1'b0);
        check_vec("cal_not_done_early", {31'd0, calib_done}, 32'd0);
        send_pair(d, 1'b0);
        check_vec("cal_done", {31'd0, calib_done}, 32'd1);
        check_vec("cal_offset", {16'd0, gy_offset}, {16'd0, exp_off});
        check_vec("cal_no_strobe", {31'd0, is_read}, 32'd0);
    endtask

    // One RUN sample: the strobe must be high one cycle after the low byte, for one cycle only.
    task automatic run_pair(input string tag, input logic [15:0] raw, input logic [15:0] exp_g);
        send_pair(raw, 1'b0);
        exp_strobes++;
        check_vec({tag, "_strobe"}, {31'd0, is_read}, 32'd1);
        check_vec({tag, "_G"}, {16'd0, G}, {16'd0, exp_g});
        @(posedge clk);
        #1;
        check_vec({tag, "_strobe_end"}, {31'd0, is_read}, 32'd0);
        check_vec({tag, "_G_hold"}, {16'd0, G}, {16'd0, exp_g});
    endtask

    initial begin
        rst        = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        byte_sof   = 1'b0;
        recal      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_vec("rst_G", {16'd0, G}, 32'd0);
        check_vec("rst_is_read", {31'd0, is_read}, 32'd0);
        check_vec("rst_calib_done", {31'd0, calib_done}, 32'd0);
        check_vec("rst_offset", {16'd0, gy_offset}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Average 16,18,14,16 -> 16, then 0x15 - 0x10 = 5.
        cal4(16'h0010, 16'h0012, 16'h000E, 16'h0010, 16'h0010);
        run_pair("basic", 16'h0015, 16'h0005);

        // A low byte with no preceding high byte is dropped.
        send_byte(8'h77, 1'b0, 1'b0);
        check_vec("orphan_no_strobe", {31'd0, is_read}, 32'd0);
        check_vec("orphan_G_hold", {16'd0, G}, 32'h0005);

        // A second high byte replaces the first: raw 0x3456 - 0x10 = 0x3446.
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0);
        exp_strobes++;
        check_vec("resof_strobe", {31'd0, is_read}, 32'd1);
        check_vec("resof_G", {16'd0, G}, 32'h3446);

        // recal together with a RUN low byte: the pair is discarded and the old offset kept.
        send_pair(16'h0100, 1'b1);
        check_vec("recal_pair_no_strobe", {31'd0, is_read}, 32'd0);
        check_vec("recal_pair_calib_done", {31'd0, calib_done}, 32'd0);
        check_vec("recal_pair_offset_hold", {16'd0, gy_offset}, 32'h0010);
        check_vec("recal_pair_G_hold", {16'd0, G}, 32'h3446);

        // -3,-3,-2,-2 sums to -10; floor(-10/4) = -3.
        cal4(16'hFFFD, 16'hFFFD, 16'hFFFE, 16'hFFFE, 16'hFFFD);
        run_pair("neg_off", 16'h0000, EXP_G_SMALL3);

        // Positive saturation: 0x7FFF - (-16).
        pulse_recal();
        cal4(16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0);
        run_pair("sat_pos", 16'h7FFF, 16'h7FFF);

        // Negative saturation: 0x8000 - 16.
        pulse_recal();
        cal4(16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010);
        run_pair("sat_neg", 16'h8000, 16'h8000);

        pulse_recal();
        cal4(16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020);
        run_pair("off20", 16'h0010, 16'hFFF0);

        // recal during CALIB restarts the count, so the earlier 0x100 samples are forgotten.
        pulse_recal();
        send_pair(16'h0100, 1'b0);
        send_pair(16'h0100, 1'b0);
        pulse_recal();
        send_pair(16'h0008, 1'b0);
        send_pair(16'h0008, 1'b0);
        check_vec("restart_not_done", {31'd0, calib_done}, 32'd0);
        send_pair(16'h0008, 1'b0);
        send_pair(16'h0008, 1'b0);
        check_vec("restart_done", {31'd0, calib_done}, 32'd1);
        check_vec("restart_offset", {16'd0, gy_offset}, 32'h0008);

        // Asynchronous reset in the middle of calibration, asserted away from any clock edge.
        pulse_recal();
        send_pair(16'h0040, 1'b0);
        send_pair(16'h0040, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_vec("async_rst_G", {16'd0, G}, 32'd0);
        check_vec("async_rst_is_read", {31'd0, is_read}, 32'd0);
        check_vec("async_rst_calib_done", {31'd0, calib_done}, 32'd0);
        check_vec("async_rst_offset", {16'd0, gy_offset}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero offset: small values (deadband only when built in) and -5 just outside it.
        cal4(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_pair("db_small", 16'h0004, EXP_G_SMALL4);
        run_pair("db_edge", 16'hFFFB, 16'hFFFB);

        repeat (2) @(posedge clk);
        #1;
        check_vec("total_strobes", strobe_cnt, exp_strobes);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/gyro_sample_fetch.md
Name: gyro_sample_fetch

Overview:
Stage directly upstream of the gyro float-conversion stage. It assembles the MPU6050 gyro register byte pair from the I2C reader's byte stream into a signed 16-bit sample. After reset it calibrates a zero-rate offset by averaging 2^CAL_SHIFT samples, then subtracts that offset with saturation. Each result is presented on G with a one-cycle is_read strobe.

Parameters:
CAL_SHIFT, 8, log2 of the number of samples averaged for offset calibration (legal range 1..12).
DEADBAND, 4, magnitude at or below which corrected samples are forced to 0. Used only when GYRO_DEADBAND_EN is defined.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
byte_in  input  8  data byte from the I2C reader.
byte_valid  input  1  byte_in is valid this cycle.
byte_sof  input  1  qualifies byte_valid; 1 means byte_in is the high byte (GYRO_xOUT_H).
recal  input  1  single-cycle request to restart offset calibration.
G  output  16  offset-corrected signed gyro sample.
is_read  output  1  one-cycle strobe; G is valid while it is high.
calib_done  output  1  high once a valid offset is in use.
gy_offset  output  16  current signed offset, for debug.

Behaviour:
- Reset is asynchronous, active-high. While rst is high:
  - G=0, is_read=0, calib_done=0, gy_offset=0.
  - Accumulator=0, sample counter=0, have_hi=0, state=CALIB.
- Byte pairing:
  - byte_valid with byte_sof=1: capture the high byte and set have_hi. If have_hi is already set, the new high byte replaces the old one.
  - byte_valid with byte_sof=0 and have_hi=1: form raw={hi,byte_in}, signed. Clear have_hi. Raise an internal pair_done for that cycle.
  - byte_valid with byte_sof=0 and have_hi=0: drop the byte silently.
- State CALIB:
  - On each pair_done, add sign-extended raw to a (16+CAL_SHIFT)-bit signed accumulator and increment the counter.
  - When the counter reaches 2^CAL_SHIFT (that pair included):
    - gy_offset = accumulator >>> CAL_SHIFT (arithmetic shift, i.e. floor).
    - Clear accumulator and counter.
    - calib_done goes to 1 on the next clock edge.
    - State becomes RUN.
  - is_read is never asserted in CALIB.
- State RUN:
  - On pair_done, compute diff = raw - gy_offset in 17 bits.
  - Saturate diff to [-32768, 32767] and register it into G.
  - is_read is high the cycle after the accepting clock edge (latency 1 cycle from the low byte), for exactly one cycle.
  - G holds its value until the next strobe.
  - Back-to-back low bytes on consecutive cycles are impossible: a new high byte is always required between them.
- recal:
  - When sampled high in either state, the next state is CALIB.
  - calib_done=0 and the accumulator and counter are cleared.
  - gy_offset keeps its old value until the new calibration completes.
  - have_hi is not cleared.
- Simultaneous recal and pair_done: recal wins. The pair is discarded, with no is_read and no accumulation.
- recal while already in CALIB restarts the count from zero.
- G is not cleared by recal; it holds its last RUN value.

Optional Feature:
GYRO_DEADBAND_EN
- Defined: in RUN, a saturated result with |result| <= DEADBAND is output as 0. The strobe is still issued.
- Undefined: DEADBAND is ignored and the saturated difference is output unchanged.

Test Plan:
- CAL_SHIFT=2. Feed raw 0x0010, 0x0012, 0x000E, 0x0010 -> gy_offset=0x0010 and calib_done=1 one cycle after the 4th low byte, with no is_read. Then raw 0x0015 -> G=0x0005, is_read high for exactly one cycle, one cycle after the low byte.
- CAL_SHIFT=2. Feed raw -3, -3, -2, -2 -> gy_offset=0xFFFD (floor of -2.5). Then raw 0x0000 -> G=0x0003.
- Saturation, offset 0xFFF0 (-16):
  - Raw 0x7FFF -> G=0x7FFF.
  - With offset 0x0010, raw 0x8000 -> G=0x8000.
- Framing:
  - Low byte with no preceding sof is dropped, with no strobe.
  - Two sof bytes 0x12 then 0x34, followed by low byte 0x56 -> raw 0x3456.
- recal:
  - Pulse recal in the same cycle as a RUN low byte -> no is_read, calib_done falls the next cycle, old gy_offset holds.
  - After 4 new samples of 0x0020 -> gy_offset=0x0020.
  - Assert rst mid-calibration -> all outputs 0 asynchronously.
- With GYRO_DEADBAND_EN and DEADBAND=4, offset 0:
  - Raw 0x0004 -> G=0, is_read pulses.
  - Raw 0xFFFB (-5) -> G=0xFFFB.
